ddr4_dimm: RTL and testbench

Cycle-level behavioural model of a registered DDR4 DIMM used as the memory target in emulation benches. It decodes DDR4 command pins per rank, tracks per-bank open/closed state and the open row for every rank/bank-group/bank, and serves read and write bursts from a small emulation-memory cache. It sits between a memory-controller model and bench monitors; a per-bank `sync` input lets the host freeze individual banks.

---
 rtl/ddr4_dimm.sv | 215 +++++++++++++++++++++
 tb/tb_ddr4_dimm.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_dimm.sv
`default_nettype none
// ============================================================================
// Module   : ddr4_dimm
// Purpose  : Cycle-level registered DDR4 DIMM model for emulation benches.
//            Decodes command pins per rank, tracks per-bank open row, and
//            serves fixed-latency read/write bursts from a small cache.
// Revision : 1.0 - initial release
// ============================================================================
module ddr4_dimm #(
    parameter int RANKS        = 1,
    parameter int CHIPS        = 18,
    parameter int BGWIDTH      = 2,
    parameter int BAWIDTH      = 2,
    parameter int ADDRWIDTH    = 17,
    parameter int COLWIDTH     = 10,
    parameter int DEVICE_WIDTH = 4,
    parameter int BL           = 8,
    parameter int CHWIDTH      = 5,
    localparam int DQWIDTH     = DEVICE_WIDTH * CHIPS
) (
    input  logic                 ck_t,
    input  logic                 reset,
    input  logic                 cke,
    input  logic [RANKS-1:0]     cs_n,
    input  logic                 act_n,
    input  logic [ADDRWIDTH-1:0] A,
    input  logic [BGWIDTH-1:0]   bg,
    input  logic [BAWIDTH-1:0]   ba,
    inout  wire  [DQWIDTH-1:0]   dq,
    inout  wire  [CHIPS-1:0]     dqs_t,
    inout  wire  [CHIPS-1:0]     dqs_c,
    input  logic                 odt,
    input  logic                 parity,
    input  logic                 sync [2**BGWIDTH][2**BAWIDTH]
);

    localparam int c_NBG   = 2 ** BGWIDTH;
    localparam int c_NBA   = 2 ** BAWIDTH;
    localparam int c_NBANK = c_NBG * c_NBA;
    localparam int c_NTOT  = RANKS * c_NBANK;
    localparam int c_RW    = (RANKS > 1) ? $clog2(RANKS) : 1;
    localparam int c_BIW   = $clog2(c_NTOT);
    localparam int c_CHD   = 2 ** CHWIDTH;
    localparam int c_DEPTH = c_NTOT * c_CHD * BL;
    localparam int c_AW    = $clog2(c_DEPTH);
    localparam int c_BW    = (BL > 1) ? $clog2(BL) : 1;
    localparam int c_CW    = 8;
    localparam int c_RL    = 4;
    localparam int c_WL    = 3;

    // Burst counter milestones (counter is 0 in the cycle after the command edge)
    localparam logic [c_CW-1:0] c_RD_FIRST = c_CW'(c_RL);
    localparam logic [c_CW-1:0] c_RD_END   = c_CW'(c_RL + BL - 1);
    localparam logic [c_CW-1:0] c_WR_FIRST = c_CW'(c_WL - 1);
    localparam logic [c_CW-1:0] c_WR_LAST  = c_CW'(c_WL + BL - 2);
    localparam logic [c_CW-1:0] c_WR_END   = c_CW'(c_WL + BL - 1);

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACTIVE = 1'b1;

    // ---------------- command decode ----------------
    logic            w_seen;
    logic            w_multi;
    logic [c_RW-1:0] w_rank;

    // Find the single selected rank; more than one low cs_n kills the command
    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        w_rank  = '0;
        for (int r = 0; r < RANKS; r++) begin
            if (!cs_n[r]) begin
                if (w_seen) w_multi = 1'b1;
                w_seen = 1'b1;
                w_rank = c_RW'(r);
            end
        end
    end

    logic          w_valid;
    logic [2:0]    w_op;
    logic          w_pre_op;
    logic          w_rd;
    logic          w_wr;
    logic          w_sync;
    logic [COLWIDTH-1:0] w_col;

    assign w_valid  = cke && w_seen && !w_multi;
    assign w_op     = A[16:14];
    assign w_pre_op = w_valid && act_n && (w_op == 3'b010);
    assign w_rd     = w_valid && act_n && (w_op == 3'b101);
    assign w_wr     = w_valid && act_n && (w_op == 3'b100);
    assign w_sync   = sync[bg][ba];
    assign w_col    = A[COLWIDTH-1:0];

    // ---------------- per-bank state ----------------
    logic [c_NTOT-1:0]    w_open;
    logic [ADDRWIDTH-1:0] w_rows [c_NTOT];

    for (genvar gi = 0; gi < c_NTOT; gi++) begin : g_bank
        localparam int c_R = gi / c_NBANK;
        localparam int c_G = (gi / c_NBA) % c_NBG;
        localparam int c_B = gi % c_NBA;

        logic                 w_frozen;
        logic                 w_rank_hit;
        logic                 w_addr_hit;
        logic [0:0]           r_state;
        logic [ADDRWIDTH-1:0] r_row;

        assign w_frozen   = sync[c_G][c_B];
        assign w_rank_hit = w_valid && (int'(w_rank) == c_R);
        assign w_addr_hit = (int'(bg) == c_G) && (int'(ba) == c_B);

        // IDLE/ACTIVE tracking; a frozen bank ignores every command, PREA included
        always_ff @(posedge ck_t or posedge reset) begin
            if (reset) begin
                r_state <= c_IDLE;
                r_row   <= '0;
            end else if (w_rank_hit && !w_frozen) begin
                case (r_state)
                    c_IDLE: begin
                        if (!act_n && w_addr_hit) begin
                            r_state <= c_ACTIVE;
                            r_row   <= A;
                        end
                    end
                    c_ACTIVE: begin
                        if (act_n && (w_op == 3'b010) && (A[10] || w_addr_hit))
                            r_state <= c_IDLE;
                    end
                    default: r_state <= c_IDLE;
                endcase
            end
        end

        assign w_open[gi] = (r_state == c_ACTIVE);
        assign w_rows[gi] = r_row;
    end

    // ---------------- burst engine ----------------
    logic [c_BIW-1:0]     w_tgt;
    logic [ADDRWIDTH-1:0] w_tgt_row;
    logic [CHWIDTH-1:0]   w_chidx;
    logic [c_AW-1:0]      w_base;

    assign w_tgt     = c_BIW'(int'(w_rank) * c_NBANK + int'(bg) * c_NBA + int'(ba));
    assign w_tgt_row = w_rows[w_tgt];

    if (CHWIDTH > 3) begin : g_chidx_row
        assign w_chidx = {w_tgt_row[CHWIDTH-4:0], w_col[5:3]};
    end else begin : g_chidx_col
        assign w_chidx = w_col[5:3];
    end

    assign w_base = c_AW'((int'(w_tgt) * c_CHD + int'(w_chidx)) * BL);

    logic            r_busy;
    logic            r_is_rd;
    logic [c_CW-1:0] r_cnt;
    logic [c_AW-1:0] r_base;
    logic [c_CW-1:0] w_end;
    logic            w_free;
    logic            w_start;

    assign w_end   = r_is_rd ? c_RD_END : c_WR_END;
    assign w_free  = !r_busy || (r_cnt == w_end);
    assign w_start = (w_rd || w_wr) && w_open[w_tgt] && !w_sync && w_free;

    // Single bus owner: latch the cache slot at accept, count through the burst
    always_ff @(posedge ck_t or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_is_rd <= 1'b0;
            r_cnt   <= '0;
            r_base  <= '0;
        end else if (w_start) begin
            r_busy  <= 1'b1;
            r_is_rd <= w_rd;
            r_cnt   <= '0;
            r_base  <= w_base;
        end else if (r_busy) begin
            if (r_cnt == w_end) r_busy <= 1'b0;
            else                r_cnt  <= r_cnt + c_CW'(1);
        end
    end

    logic              w_rd_drive;
    logic              w_wr_take;
    logic [c_BW-1:0]   w_rbeat;
    logic [c_BW-1:0]   w_wbeat;
    logic [DQWIDTH-1:0] w_rdata;
    logic [DQWIDTH-1:0] r_mem [c_DEPTH];

    assign w_rd_drive = r_busy && r_is_rd && (r_cnt >= c_RD_FIRST) && (r_cnt <= c_RD_END);
    assign w_wr_take  = r_busy && !r_is_rd && (r_cnt >= c_WR_FIRST) && (r_cnt <= c_WR_LAST);
    assign w_rbeat    = c_BW'(r_cnt - c_RD_FIRST);
    assign w_wbeat    = c_BW'(r_cnt - c_WR_FIRST);
    assign w_rdata    = r_mem[r_base + c_AW'(w_rbeat)];

    // Cache storage is deliberately never cleared; write beats land one per edge
    always_ff @(posedge ck_t) begin
        if (w_wr_take) r_mem[r_base + c_AW'(w_wbeat)] <= dq;
    end

    assign dq    = w_rd_drive ? w_rdata                 : {DQWIDTH{1'bz}};
    assign dqs_t = w_rd_drive ? {CHIPS{~w_rbeat[0]}}    : {CHIPS{1'bz}};
    assign dqs_c = w_rd_drive ? {CHIPS{w_rbeat[0]}}     : {CHIPS{1'bz}};

    // odt/parity are accepted but have no effect; upper row/column bits are unused
    logic w_unused;
    assign w_unused = ^{odt, parity, w_tgt_row, w_col};

endmodule
`default_nettype wire

// File: tb/tb_ddr4_dimm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr4_dimm
// Purpose  : Directed self-checking bench for ddr4_dimm with a behavioural
//            bank/cache model and a per-cycle data-bus comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_dimm;

    localparam int DQW = 72;
    localparam int NCH = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cke;
    logic [0:0]  cs_n;
    logic        act_n;
    logic [16:0] A;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        odt;
    logic        parity;
    logic        sync [4][4];
    wire  [DQW-1:0] dq;
    wire  [NCH-1:0] dqs_t;
    wire  [NCH-1:0] dqs_c;

    logic           tb_en;
    logic [DQW-1:0] tb_dq;
    assign dq = tb_en ? tb_dq : {DQW{1'bz}};

    // Undriven bus floats high so "not driven" is observable as all ones
    for (genvar i = 0; i < DQW; i++) begin : g_pull_dq
        pullup pu (dq[i]);
    end
    for (genvar i = 0; i < NCH; i++) begin : g_pull_dqs
        pullup put (dqs_t[i]);
        pullup puc (dqs_c[i]);
    end

    ddr4_dimm dut (
        .ck_t(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .A(A), .bg(bg), .ba(ba), .dq(dq), .dqs_t(dqs_t), .dqs_c(dqs_c),
        .odt(odt), .parity(parity), .sync(sync)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_n = 0;

    // Model state: open flag and row per bank, cache contents, expected bus
    bit             m_open [16];
    int             m_row  [16];
    int             m_bus_free = 0;
    logic [DQW-1:0] m_mem   [int];
    logic [DQW-1:0] exp_dq  [int];
    bit             exp_kn  [int];
    bit             exp_odd [int];
    logic [DQW-1:0] drv_dq  [int];

    localparam logic [DQW-1:0] ONES  = {DQW{1'b1}};
    localparam logic [DQW-1:0] SONES = {{(DQW-NCH){1'b0}}, {NCH{1'b1}}};

    task automatic check(input string name, input logic [DQW-1:0] got, input logic [DQW-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, got, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_open[i] = 1'b0;
        m_bus_free = 0;
        exp_dq.delete();
        exp_kn.delete();
        exp_odd.delete();
        drv_dq.delete();
    endtask

    task automatic model_cmd(input bit c_cke, input bit c_cs, input bit c_act, input logic [16:0] a,
                             input int g, input int b, input int n, input logic [DQW-1:0] wbase);
        int idx;
        int ent;
        int key;
        idx = g * 4 + b;
        if (!c_cke || c_cs) return;
        if (!c_act) begin
            if (!sync[g][b] && !m_open[idx]) begin
                m_open[idx] = 1'b1;
                m_row[idx]  = int'(a);
            end
            return;
        end
        if (a[16:14] == 3'b010) begin
            for (int i = 0; i < 16; i++)
                if ((a[10] || i == idx) && !sync[i / 4][i % 4]) m_open[i] = 1'b0;
        end else if ((a[16:14] == 3'b101 || a[16:14] == 3'b100) && !sync[g][b] && m_open[idx] && n >= m_bus_free) begin
            ent = idx * 32 + (m_row[idx] % 4) * 8 + int'(a[5:3]);
            for (int k = 0; k < 8; k++) begin
                key = ent * 8 + k;
                if (a[16:14] == 3'b101) begin
                    exp_kn[n + 4 + k]  = m_mem.exists(key);
                    exp_dq[n + 4 + k]  = m_mem.exists(key) ? m_mem[key] : '0;
                    exp_odd[n + 4 + k] = (k % 2) == 1;
                end else begin
                    m_mem[key]         = wbase + DQW'(k);
                    drv_dq[n + 2 + k]  = wbase + DQW'(k);
                end
            end
            m_bus_free = n + ((a[16:14] == 3'b101) ? 12 : 11);
        end
    endtask

    // Present one command for one edge, then return to NOP and update the model
    task automatic issue(input bit c_cke, input bit c_cs, input bit c_act, input logic [16:0] a,
                         input int g, input int b, input logic [DQW-1:0] wbase);
        logic [1:0] gg;
        logic [1:0] bb;
        gg = 2'(g);
        bb = 2'(b);
        cke = c_cke; cs_n = c_cs; act_n = c_act; A = a; bg = gg; ba = bb;
        @(posedge clk);
        @(negedge clk);
        last_n = cyc;
        cke = 1'b1; cs_n = 1'b0; act_n = 1'b1; A = {3'b111, 14'd0};
        model_cmd(c_cke, c_cs, c_act, a, g, b, last_n, wbase);
    endtask

    task automatic act(input int g, input int b, input int row);
        issue(1'b1, 1'b0, 1'b0, 17'(row), g, b, '0);
    endtask
    task automatic rd(input int g, input int b, input int col);
        issue(1'b1, 1'b0, 1'b1, {3'b101, 4'd0, 10'(col)}, g, b, '0);
    endtask
    task automatic wr(input int g, input int b, input int col, input logic [DQW-1:0] base);
        issue(1'b1, 1'b0, 1'b1, {3'b100, 4'd0, 10'(col)}, g, b, base);
    endtask
    task automatic pre(input int g, input int b, input bit all);
        issue(1'b1, 1'b0, 1'b1, {3'b010, 3'd0, all, 10'd0}, g, b, '0);
    endtask
    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Write-data driver: beat k is presented in the cycle before its sampling edge
    initial begin
        tb_en = 1'b0;
        tb_dq = '0;
        forever begin
            @(negedge clk);
            if (drv_dq.exists(cyc)) begin
                tb_en = 1'b1;
                tb_dq = drv_dq[cyc];
            end else begin
                tb_en = 1'b0;
            end
        end
    end

    // Per-cycle comparator against the model's expected bus activity
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (exp_dq.exists(cyc)) begin
                if (exp_kn[cyc]) check("rd_dq", dq, exp_dq[cyc]);
                check("rd_dqs_t", {{(DQW-NCH){1'b0}}, dqs_t}, {{(DQW-NCH){1'b0}}, {NCH{~exp_odd[cyc]}}});
                check("rd_dqs_c", {{(DQW-NCH){1'b0}}, dqs_c}, {{(DQW-NCH){1'b0}}, {NCH{exp_odd[cyc]}}});
            end else if (!tb_en) begin
                check("idle_dq", dq, ONES);
                check("idle_dqs", {{(DQW-NCH){1'b0}}, dqs_t & dqs_c}, SONES);
            end
        end
    end

    initial begin
        int n0;
        reset = 1'b1; cke = 1'b1; cs_n = 1'b0; act_n = 1'b1; A = {3'b111, 14'd0};
        bg = '0; ba = '0; odt = 1'b0; parity = 1'b0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) sync[i][j] = 1'b0;
        model_reset();
        idle(2);
        reset = 1'b0;
        #1 check("reset_dq", dq, ONES);

        // All 16 banks activated with row 1, then exercise the last one
        for (int i = 0; i < 16; i++) act(i / 4, i % 4, 1);
        idle(1);
        wr(3, 3, 'h10, 72'h1000);
        idle(11);
        rd(3, 3, 'h10);
        idle(12);

        // Already-open bank: ACT ignored; beat-index pattern read back at RL=4
        act(1, 2, 1);
        wr(1, 2, 'h08, 72'h0);
        idle(11);
        rd(1, 2, 'h08);
        n0 = last_n;
        idle(4);
        #1 check("lit_beat0", dq, 72'd0);
        check("lit_dqs0", {{(DQW-NCH){1'b0}}, dqs_t}, SONES);
        idle(3);
        #1 check("lit_beat3", dq, 72'd3);
        check("lit_dqs3", {{(DQW-NCH){1'b0}}, dqs_t}, '0);
        idle(4);
        #1 check("lit_beat7", dq, 72'd7);
        idle(1);
        #1 check("lit_after", dq, ONES);
        check("lit_cyc", DQW'(cyc - n0), DQW'(12));
        idle(2);

        // Reset in the middle of a read burst
        rd(1, 2, 'h08);
        idle(5);
        #2 reset = 1'b1;
        #1 check("rst_mid_dq", dq, ONES);
        check("rst_mid_dqs_t", {{(DQW-NCH){1'b0}}, dqs_t}, SONES);
        check("rst_mid_dqs_c", {{(DQW-NCH){1'b0}}, dqs_c}, SONES);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        rd(1, 2, 'h08);
        idle(12);
        act(1, 2, 1);
        rd(1, 2, 'h08);
        idle(12);

        // Single-bank PRE leaves others open; PREA closes everything
        act(0, 0, 1);
        act(3, 1, 1);
        wr(0, 0, 0, 72'h55);
        idle(11);
        pre(3, 1, 1'b0);
        rd(0, 0, 0);
        idle(12);
        rd(3, 1, 0);
        idle(12);
        pre(0, 0, 1'b1);
        rd(0, 0, 0);
        idle(12);

        // Frozen bank drops ACT and its share of PREA
        sync[2][3] = 1'b1;
        act(2, 3, 2);
        wr(2, 3, 'h18, 72'h300);
        idle(11);
        rd(2, 3, 'h18);
        idle(12);
        sync[2][3] = 1'b0;
        act(2, 3, 2);
        wr(2, 3, 'h18, 72'h300);
        idle(11);
        rd(2, 3, 'h18);
        idle(12);
        sync[2][3] = 1'b1;
        pre(0, 0, 1'b1);
        sync[2][3] = 1'b0;
        rd(2, 3, 'h18);
        idle(12);

        // Second RD two cycles later is dropped; RD at the free edge is taken
        rd(2, 3, 'h18);
        n0 = last_n;
        idle(1);
        rd(2, 3, 'h18);
        idle(9);
        #1 check("rdrd_beat7", dq, 72'h307);
        idle(1);
        #1 check("rdrd_idle12", dq, ONES);
        idle(1);
        #1 check("rdrd_idle13", dq, ONES);
        check("rdrd_cyc", DQW'(cyc - n0), DQW'(13));
        idle(2);
        rd(2, 3, 'h18);
        idle(11);
        rd(2, 3, 'h18);
        idle(4);
        #1 check("b2b_beat0", dq, 72'h300);
        idle(10);

        // cke low and deselected rank both suppress ACT
        pre(0, 0, 1'b1);
        issue(1'b0, 1'b0, 1'b0, 17'd1, 0, 0, '0);
        rd(0, 0, 0);
        idle(12);
        issue(1'b1, 1'b1, 1'b0, 17'd1, 0, 1, '0);
        rd(0, 1, 0);
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
